lock_arbiter: RTL and testbench

Round-robin arbiter granting exclusive ownership of one shared resource (lock, bus, FSM datapath) to one of N requesters. It enforces a maximum hold time and forcibly revokes a grant that is not released in time, so a stuck owner cannot deadlock the other requesters. It sits between the requesting FSMs and the shared resource, and its one-hot grant drives the resource select.

---
 rtl/lock_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 39 +++
 rtl/lock_arbiter.sv | 116 +++++++++++
 tb/tb_lock_arbiter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/lock_arb_pkg.sv
// Shared definitions for the lock arbiter: FSM state encoding and default sizing.
package lock_arb_pkg;

    // Arbiter FSM states; code 2'b11 is never entered and falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OWNED  = 2'b01,
        REVOKE = 2'b10
    } arb_state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_HOLD_MAX = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr,
// wrapping modulo N (explicit wrap, so non-power-of-2 N works).
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   pick,
    output logic [IDW-1:0] idx,
    output logic           valid
);

    // Index ptr+off, folded back into 0..N-1.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return IDW'(s);
    endfunction

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        logic [IDW-1:0] j;
        pick  = '0;
        idx   = '0;
        valid = 1'b0;
        j     = '0;
        for (int i = 0; i < N; i++) begin
            j = wrap_add(ptr, i);
            if (!valid && req[j]) begin
                pick[j] = 1'b1;
                idx     = j;
                valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lock_arbiter.sv
// Round-robin lock arbiter with bounded tenure: a grant not released within
// HOLD_MAX cycles is forcibly revoked so a stuck owner cannot starve others.
module lock_arbiter
    import lock_arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int HOLD_MAX = DEF_HOLD_MAX,
    parameter int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   rel,
    output logic [N-1:0]   gnt,
    output logic           busy,
    output logic [IDW-1:0] owner,
    output logic           revoke,
    output logic [IDW-1:0] revoked_id
);

    localparam int HCW = $clog2(HOLD_MAX);

    arb_state_t     state_q, state_d;
    logic [HCW-1:0] hold_cnt, hold_d;
    logic [IDW-1:0] ptr, ptr_d;
    logic [N-1:0]   gnt_d;
    logic [IDW-1:0] owner_d;
    logic           revoke_d;
    logic [IDW-1:0] revoked_id_d;

    logic [N-1:0]   pick;
    logic [IDW-1:0] pick_idx;
    logic           pick_valid;

    // Next index after i, with explicit wrap at N-1.
    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        if (i == IDW'(N - 1)) return '0;
        return i + IDW'(1);
    endfunction

    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .pick  (pick),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Next-state and output decode; everything holds unless a transition says otherwise.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_cnt;
        ptr_d        = ptr;
        gnt_d        = gnt;
        owner_d      = owner;
        revoke_d     = 1'b0;
        revoked_id_d = revoked_id;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick;
                    owner_d = pick_idx;
                    hold_d  = '0;
                    state_d = OWNED;
                end
            end
            OWNED: begin
                // Release takes priority over a timeout landing in the same cycle.
                if (rel[owner]) begin
                    gnt_d   = '0;
                    ptr_d   = next_idx(owner);
                    state_d = IDLE;
                end else if (hold_cnt == HCW'(HOLD_MAX - 1)) begin
                    gnt_d        = '0;
                    revoke_d     = 1'b1;
                    revoked_id_d = owner;
                    ptr_d        = next_idx(owner);
                    state_d      = REVOKE;
                end else begin
                    hold_d = hold_cnt + HCW'(1);
                end
            end
            REVOKE: begin
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset overriding all events.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_cnt   <= '0;
            ptr        <= '0;
            gnt        <= '0;
            owner      <= '0;
            revoke     <= 1'b0;
            revoked_id <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt   <= hold_d;
            ptr        <= ptr_d;
            gnt        <= gnt_d;
            owner      <= owner_d;
            revoke     <= revoke_d;
            revoked_id <= revoked_id_d;
        end
    end

    assign busy = |gnt;

endmodule

// File: tb/tb_lock_arbiter.sv
// Directed scoreboard bench for lock_arbiter with N=4, HOLD_MAX=8.
module tb_lock_arbiter;

    localparam int N   = 4;
    localparam int HM  = 8;
    localparam int IDW = 2;

    logic           clk   = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req   = '0;
    logic [N-1:0]   rel   = '0;
    logic [N-1:0]   gnt;
    logic           busy;
    logic [IDW-1:0] owner;
    logic           revoke;
    logic [IDW-1:0] revoked_id;

    lock_arbiter #(.N(N), .HOLD_MAX(HM), .IDW(IDW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .rel        (rel),
        .gnt        (gnt),
        .busy       (busy),
        .owner      (owner),
        .revoke     (revoke),
        .revoked_id (revoked_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] gnt;
        logic       busy;
        logic [1:0] owner;
        logic       revoke;
        logic [1:0] rid;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input string fld, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s/%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected registered outputs, then
    // check them 1 time unit after the next rising edge.
    task automatic cyc(input string tag, input logic rs, input logic [3:0] r, input logic [3:0] l,
                       input logic [3:0] eg, input logic [1:0] eo, input logic erv, input logic [1:0] erid);
        exp_t e;
        reset = rs;
        req   = r;
        rel   = l;
        e.tag    = tag;
        e.gnt    = eg;
        e.busy   = |eg;
        e.owner  = eo;
        e.revoke = erv;
        e.rid    = erid;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(e.tag, "gnt",        gnt,                 e.gnt);
        chk(e.tag, "busy",       {3'b000, busy},      {3'b000, e.busy});
        chk(e.tag, "owner",      {2'b00, owner},      {2'b00, e.owner});
        chk(e.tag, "revoke",     {3'b000, revoke},    {3'b000, e.revoke});
        chk(e.tag, "revoked_id", {2'b00, revoked_id}, {2'b00, e.rid});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] oh;
        oh = '0;

        // Reset state
        cyc("reset0", 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0);
        cyc("reset1", 1'b1, 4'b0101, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0);

        // Basic grant, release, rotation, non-owner release ignored
        cyc("grant0",       1'b0, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b0, 2'd0);
        cyc("rel0",         1'b0, 4'b0101, 4'b0001, 4'b0000, 2'd0, 1'b0, 2'd0);
        cyc("rotate2",      1'b0, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b0, 2'd0);
        cyc("nonowner_rel", 1'b0, 4'b0101, 4'b0001, 4'b0100, 2'd2, 1'b0, 2'd0);
        cyc("rel2",         1'b0, 4'b0101, 4'b0100, 4'b0000, 2'd2, 1'b0, 2'd0);

        // Timeout: owner 1 never releases; scan from ptr=3 wraps to 1
        cyc("grant1_wrap",  1'b0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0, 2'd0);
        for (int k = 0; k < HM - 1; k++)
            cyc("to_hold",  1'b0, 4'b0110, 4'b0000, 4'b0010, 2'd1, 1'b0, 2'd0);
        cyc("to_revoke",    1'b0, 4'b0110, 4'b0000, 4'b0000, 2'd1, 1'b1, 2'd1);
        cyc("to_gap",       1'b0, 4'b0110, 4'b0000, 4'b0000, 2'd1, 1'b0, 2'd1);
        cyc("to_regrant2",  1'b0, 4'b0110, 4'b0000, 4'b0100, 2'd2, 1'b0, 2'd1);

        // Release in the same cycle the timeout would fire
        for (int k = 0; k < HM - 1; k++)
            cyc("edge_hold", 1'b0, 4'b0110, 4'b0000, 4'b0100, 2'd2, 1'b0, 2'd1);
        cyc("edge_rel",     1'b0, 4'b0110, 4'b0100, 4'b0000, 2'd2, 1'b0, 2'd1);
        cyc("edge_idle",    1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 2'd1);

        // Mid-tenure reset, then lowest-index requester wins
        cyc("grant3",       1'b0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0, 2'd1);
        cyc("mid_reset",    1'b1, 4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0);
        cyc("post_reset",   1'b0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b0, 2'd0);
        cyc("post_rel",     1'b0, 4'b1010, 4'b0010, 4'b0000, 2'd1, 1'b0, 2'd0);

        // Fairness: all requesting, each owner releases after two cycles
        cyc("fair_reset",   1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'd0);
        for (int i = 0; i < N; i++) begin
            oh = 4'b0001 << i;
            cyc("fair_grant", 1'b0, 4'b1111, 4'b0000, oh,      2'(i), 1'b0, 2'd0);
            cyc("fair_hold",  1'b0, 4'b1111, ~oh,     oh,      2'(i), 1'b0, 2'd0);
            cyc("fair_rel",   1'b0, 4'b1111, oh,      4'b0000, 2'(i), 1'b0, 2'd0);
        end
        cyc("fair_wrap0",   1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
